// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: fetch-stage lookup, execute-stage
// update, misprediction detection and redirect PC, plus resolve/mispredict counters.

module btb_entry #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (we) q <= d;
   end

endmodule

module branch_predictor #(
   parameter int INDEX_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_f,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [6:0]  ex_opcode,
   input  logic        ex_br_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] br_count,
   output logic [31:0] mis_count
);

   localparam int NUM_ENT = 1 << INDEX_W;
   localparam int TAG_W   = 30 - INDEX_W;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [31:0]      target;
      logic             jump;
      logic [1:0]       ctr;
   } btb_ent_t;

   localparam int ENT_W = $bits(btb_ent_t);

   btb_ent_t [NUM_ENT-1:0] ent_q;

   logic               upd_we;
   btb_ent_t           upd_d;
   logic [INDEX_W-1:0] ex_idx;
   logic [TAG_W-1:0]   ex_tag;

   genvar g;
   generate
      for (g = 0; g < NUM_ENT; g++) begin : g_ent
         btb_entry #(.W(ENT_W)) u_ent (
            .clk (clk),
            .rst (rst),
            .we  (upd_we && (ex_idx == INDEX_W'(g))),
            .d   (upd_d),
            .q   (ent_q[g])
         );
      end
   endgenerate

   // Lookup
   logic [INDEX_W-1:0] f_idx;
   logic [TAG_W-1:0]   f_tag;
   btb_ent_t           f_ent;
   logic               f_hit;

   assign f_idx       = pc_f[INDEX_W+1:2];
   assign f_tag       = pc_f[31:INDEX_W+2];
   assign f_ent       = ent_q[f_idx];
   assign f_hit       = f_ent.valid && (f_ent.tag == f_tag);
   assign pred_taken  = f_hit && (f_ent.jump || f_ent.ctr[1]);
   assign pred_target = pred_taken ? f_ent.target : pc_f + 32'd4;

   // Resolution
   btb_ent_t ex_ent;
   logic     ex_hit;
   logic     is_br;
   logic     is_jmp;

   assign ex_idx = ex_pc[INDEX_W+1:2];
   assign ex_tag = ex_pc[31:INDEX_W+2];
   assign ex_ent = ent_q[ex_idx];
   assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);
   assign is_br  = (ex_opcode == OP_BRANCH);
   assign is_jmp = (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);

   assign mispredict  = ex_valid &&
                        ((ex_br_taken != ex_pred_taken) ||
                         (ex_br_taken && (ex_target != ex_pred_target)));
   assign redirect_pc = ex_br_taken ? ex_target : ex_pc + 32'd4;

   always_comb begin
      upd_we = 1'b0;
      upd_d  = ex_ent;
      if (ex_valid) begin
         if (is_br) begin
            if (ex_hit) begin
               upd_we = 1'b1;
               if (ex_br_taken) begin
                  upd_d.target = ex_target;
                  if (ex_ent.ctr != 2'b11) upd_d.ctr = ex_ent.ctr + 2'd1;
               end else begin
                  if (ex_ent.ctr != 2'b00) upd_d.ctr = ex_ent.ctr - 2'd1;
               end
            end else if (ex_br_taken) begin
               upd_we       = 1'b1;
               upd_d.valid  = 1'b1;
               upd_d.tag    = ex_tag;
               upd_d.target = ex_target;
               upd_d.jump   = 1'b0;
               upd_d.ctr    = 2'b10;
            end
         end else if (is_jmp) begin
            upd_we       = 1'b1;
            upd_d.valid  = 1'b1;
            upd_d.tag    = ex_tag;
            upd_d.target = ex_target;
            upd_d.jump   = 1'b1;
            upd_d.ctr    = 2'b11;
         end else if (ex_hit) begin
            // a non-control instruction hit an aliased or stale entry
            upd_we      = 1'b1;
            upd_d.valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         br_count  <= '0;
         mis_count <= '0;
      end else begin
         if (ex_valid && (is_br || is_jmp)) br_count <= br_count + 32'd1;
         if (mispredict)                    mis_count <= mis_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: table of per-cycle inputs with
// hand-computed lookup, mispredict and counter expectations.

module tb_branch_predictor;

   localparam logic [6:0] OP_B    = 7'h63;
   localparam logic [6:0] OP_JAL  = 7'h6F;
   localparam logic [6:0] OP_JALR = 7'h67;
   localparam logic [6:0] OP_ADDI = 7'h13;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_f;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [6:0]  ex_opcode;
   logic        ex_br_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] br_count;
   logic [31:0] mis_count;

   always #5 clk = ~clk;

   branch_predictor #(.INDEX_W(6)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_f           (pc_f),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .ex_opcode      (ex_opcode),
      .ex_br_taken    (ex_br_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .br_count       (br_count),
      .mis_count      (mis_count)
   );

   typedef struct {
      logic        rst;
      logic [31:0] pc_f;
      logic        ex_valid;
      logic [31:0] ex_pc;
      logic [6:0]  op;
      logic        tk;
      logic [31:0] tgt;
      logic        ptk;
      logic [31:0] ptgt;
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic        e_mp;
      logic [31:0] e_rd;
      logic [31:0] e_br;
      logic [31:0] e_mis;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(logic r, logic [31:0] pf, logic ev, logic [31:0] epc,
                               logic [6:0] op, logic tk, logic [31:0] tgt,
                               logic ptk, logic [31:0] ptgt,
                               logic e_pt, logic [31:0] e_ptgt, logic e_mp,
                               logic [31:0] e_rd, logic [31:0] e_br, logic [31:0] e_mis);
      vec_t v;
      v.rst = r;     v.pc_f = pf;    v.ex_valid = ev; v.ex_pc = epc;
      v.op = op;     v.tk = tk;      v.tgt = tgt;     v.ptk = ptk;  v.ptgt = ptgt;
      v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_mp = e_mp; v.e_rd = e_rd;
      v.e_br = e_br; v.e_mis = e_mis;
      return v;
   endfunction

   task automatic chk(input int idx, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL vec %0d %s: got 0x%08h, expected 0x%08h", idx, name, act, exp);
      end
   endtask

   // Drive on the falling edge, check mid-low phase, state advances on the next rising edge.
   task automatic run_vec(input int idx, input vec_t v);
      @(negedge clk);
      rst            = v.rst;
      pc_f           = v.pc_f;
      ex_valid       = v.ex_valid;
      ex_pc          = v.ex_pc;
      ex_opcode      = v.op;
      ex_br_taken    = v.tk;
      ex_target      = v.tgt;
      ex_pred_taken  = v.ptk;
      ex_pred_target = v.ptgt;
      #2;
      n_vec++;
      chk(idx, "pred_taken",  {31'd0, pred_taken}, {31'd0, v.e_pt});
      chk(idx, "pred_target", pred_target,         v.e_ptgt);
      chk(idx, "mispredict",  {31'd0, mispredict}, {31'd0, v.e_mp});
      chk(idx, "redirect_pc", redirect_pc,         v.e_rd);
      chk(idx, "br_count",    br_count,            v.e_br);
      chk(idx, "mis_count",   mis_count,           v.e_mis);
   endtask

   initial begin
      rst = 1'b1; pc_f = '0; ex_valid = 1'b0; ex_pc = '0; ex_opcode = OP_ADDI;
      ex_br_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;

      //               rst pc_f          ev ex_pc         op      tk tgt      ptk ptgt      e_pt e_ptgt   e_mp e_rd     br  mis
      vecs.push_back(mk(1, 32'h100,      0, 32'h0,        OP_ADDI, 0, 32'h0,   0, 32'h0,     0, 32'h104,  0, 32'h4,   0,  0));
      vecs.push_back(mk(0, 32'h100,      1, 32'h100,      OP_B,    1, 32'h80,  0, 32'h104,   0, 32'h104,  1, 32'h80,  0,  0));
      vecs.push_back(mk(0, 32'h100,      0, 32'h100,      OP_B,    1, 32'h900, 0, 32'h104,   1, 32'h80,   0, 32'h900, 1,  1));
      vecs.push_back(mk(0, 32'h100,      1, 32'h100,      OP_B,    0, 32'h80,  1, 32'h80,    1, 32'h80,   1, 32'h104, 1,  1));
      vecs.push_back(mk(0, 32'h100,      1, 32'h100,      OP_B,    1, 32'h80,  0, 32'h104,   0, 32'h104,  1, 32'h80,  2,  2));
      vecs.push_back(mk(0, 32'h100,      1, 32'h100,      OP_B,    1, 32'h80,  1, 32'h80,    1, 32'h80,   0, 32'h80,  3,  3));
      vecs.push_back(mk(0, 32'h100,      1, 32'h100,      OP_B,    1, 32'h80,  1, 32'h80,    1, 32'h80,   0, 32'h80,  4,  3));
      vecs.push_back(mk(0, 32'h100,      1, 32'h100,      OP_B,    0, 32'h80,  1, 32'h80,    1, 32'h80,   1, 32'h104, 5,  3));
      vecs.push_back(mk(0, 32'h100,      1, 32'h100,      OP_B,    0, 32'h80,  1, 32'h80,    1, 32'h80,   1, 32'h104, 6,  4));
      vecs.push_back(mk(0, 32'h100,      0, 32'h100,      OP_B,    0, 32'h80,  1, 32'h80,    0, 32'h104,  0, 32'h104, 7,  5));
      vecs.push_back(mk(0, 32'h200,      1, 32'h200,      OP_JALR, 1, 32'h300, 0, 32'h204,   0, 32'h204,  1, 32'h300, 7,  5));
      vecs.push_back(mk(0, 32'h200,      1, 32'h200,      OP_JALR, 1, 32'h340, 1, 32'h300,   1, 32'h300,  1, 32'h340, 8,  6));
      vecs.push_back(mk(0, 32'h200,      0, 32'h200,      OP_ADDI, 0, 32'h0,   0, 32'h0,     1, 32'h340,  0, 32'h204, 9,  7));
      vecs.push_back(mk(0, 32'h100,      0, 32'h200,      OP_ADDI, 0, 32'h0,   0, 32'h0,     0, 32'h104,  0, 32'h204, 9,  7));
      vecs.push_back(mk(0, 32'h100,      1, 32'h100,      OP_JAL,  1, 32'h80,  0, 32'h104,   0, 32'h104,  1, 32'h80,  9,  7));
      vecs.push_back(mk(0, 32'h100,      1, 32'h100,      OP_ADDI, 0, 32'h0,   1, 32'h80,    1, 32'h80,   1, 32'h104, 10, 8));
      vecs.push_back(mk(0, 32'h100,      0, 32'h100,      OP_ADDI, 0, 32'h0,   0, 32'h0,     0, 32'h104,  0, 32'h104, 10, 9));
      vecs.push_back(mk(1, 32'h140,      1, 32'h140,      OP_B,    1, 32'h40,  0, 32'h144,   0, 32'h144,  1, 32'h40,  10, 9));
      vecs.push_back(mk(0, 32'h140,      0, 32'h0,        OP_ADDI, 0, 32'h0,   0, 32'h0,     0, 32'h144,  0, 32'h4,   0,  0));
      vecs.push_back(mk(0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, OP_B,    0, 32'h0,   0, 32'h0,     0, 32'h0,    0, 32'h0,   0,  0));
      vecs.push_back(mk(0, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, OP_B,    0, 32'h0,   0, 32'h0,     0, 32'h0,    0, 32'h0,   1,  0));

      @(posedge clk);
      foreach (vecs[i]) run_vec(i, vecs[i]);

      // JAL allocation, then same-index lookup with a different tag must miss
      run_vec(100, mk(0, 32'h3FC, 1, 32'h3FC, OP_JAL,  1, 32'h10, 0, 32'h400, 0, 32'h400, 1, 32'h10, 1, 0));
      run_vec(101, mk(0, 32'h3FC, 0, 32'h0,   OP_ADDI, 0, 32'h0,  0, 32'h0,   1, 32'h10,  0, 32'h4,  2, 1));
      run_vec(102, mk(0, 32'h7FC, 0, 32'h0,   OP_ADDI, 0, 32'h0,  0, 32'h0,   0, 32'h800, 0, 32'h4,  2, 1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
